// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- sequencing FSM for the multicycle RV32I core.
//
// Shares one ALU and one unified memory port across fetch, decode, execute,
// memory and writeback phases. The state and the sticky illegal flag are
// registered. Mux selects and enables are decoded from the current state
// (plus mem_ready / Zero where an access or branch resolves in that cycle).
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   op, funct3, funct7b5        instruction fields from the instruction register
//   Zero                        ALU result == 0
//   mem_ready                   memory completes the current access this cycle
//   PCWrite, AdrSrc, MemWrite,
//   MemReq, IRWrite, RegWrite   datapath enables / address select
//   ResultSrc, ALUSrcA, ALUSrcB result and ALU operand selects
//   ImmSrc                      immediate format, decoded from op in every state
//   ALUControl                  ALU operation
//   instr_done                  pulse in the last cycle of each retired instruction
//   illegal                     sticky unsupported-opcode flag
module multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       MemReq,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JAL    = 4'd10,
        LUI    = 4'd11,
        TRAP   = 4'd12
    } state_t;

    state_t     state;
    logic       illegal_r;
    logic       pcwrite_s, memwrite_s, memreq_s, irwrite_s, regwrite_s;
    logic [1:0] aluop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= state_t'(RESET_STATE);
            illegal_r <= 1'b0;
        end else begin
            case (state)
                FETCH:  if (mem_ready) state <= DECODE;
                DECODE: begin
                    case (op)
                        7'b0000011,
                        7'b0100011: state <= MEMADR;
                        7'b0110011: state <= EXECR;
                        7'b0010011: state <= EXECI;
                        7'b1100011: state <= BRANCH;
                        7'b1101111: state <= JAL;
                        7'b0110111: state <= LUI;
                        default: begin
                            state     <= TRAP;
                            illegal_r <= 1'b1;
                        end
                    endcase
                end
                MEMADR: state <= op[5] ? MEMWR : MEMRD;
                MEMRD:  if (mem_ready) state <= MEMWB;
                MEMWB:  state <= FETCH;
                MEMWR:  if (mem_ready) state <= FETCH;
                EXECR,
                EXECI:  state <= ALUWB;
                ALUWB:  state <= FETCH;
                BRANCH: state <= FETCH;
                JAL:    state <= ALUWB;
                LUI:    state <= ALUWB;
                TRAP:   state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        pcwrite_s  = 1'b0;
        AdrSrc     = 1'b0;
        memwrite_s = 1'b0;
        memreq_s   = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        aluop      = 2'b00;
        instr_done = 1'b0;
        case (state)
            FETCH: begin
                memreq_s  = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irwrite_s = mem_ready;
                pcwrite_s = mem_ready;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR, LUI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMRD: begin
                memreq_s = 1'b1;
                AdrSrc   = 1'b1;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                regwrite_s = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                memreq_s   = 1'b1;
                AdrSrc     = 1'b1;
                memwrite_s = 1'b1;
                instr_done = mem_ready;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b10;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regwrite_s = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                aluop      = 2'b01;
                pcwrite_s  = Zero ^ funct3[0];  // beq: Zero, bne: !Zero
                instr_done = 1'b1;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pcwrite_s = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes and write enables are forced low while reset is held so an
    // in-flight access is abandoned without waiting for a clock edge.
    assign PCWrite  = pcwrite_s  & rst_n;
    assign MemWrite = memwrite_s & rst_n;
    assign MemReq   = memreq_s   & rst_n;
    assign IRWrite  = irwrite_s  & rst_n;
    assign RegWrite = regwrite_s & rst_n;
    assign illegal  = illegal_r;

    always_comb begin
        case (op)
            7'b0100011: ImmSrc = 3'b001;
            7'b1100011: ImmSrc = 3'b010;
            7'b1101111: ImmSrc = 3'b011;
            7'b0110111: ImmSrc = 3'b100;
            default:    ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        case (aluop)
            2'b00: ALUControl = 4'b0000;
            2'b01: ALUControl = 4'b0001;
            default: begin
                case (funct3)
                    // only R-type (op[5]=1) subtracts; addi ignores instr[30]
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 4'b0001 : 4'b0000;
                    3'b001:  ALUControl = 4'b0110;
                    3'b010:  ALUControl = 4'b0101;
                    3'b011:  ALUControl = 4'b1001;
                    3'b100:  ALUControl = 4'b0100;
                    3'b101:  ALUControl = funct7b5 ? 4'b1000 : 4'b0111;
                    3'b110:  ALUControl = 4'b0011;
                    default: ALUControl = 4'b0010;
                endcase
            end
        endcase
    end

endmodule
